// File: rtl/collision_detect.sv
// collision_detect: pixel-stream collision detector for the Pong datapath.
// Latches sticky ball hit flags during the active frame, publishes one
// prioritised hit code per frame at the publish cycle and holds it across
// the vsync pulse. Optional macro PONG_SCORE_EN builds goal scoring,
// goal_lock/serve handling and game_over; without it those outputs are 0.
module collision_detect #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned WALL_W    = 8,
   parameter int unsigned GOAL_W    = 8,
   parameter int unsigned MAX_SCORE = 9,
   parameter int unsigned SCORE_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [9:0]         hcount,
   input  logic [9:0]         vcount,
   input  logic               vsync,
   input  logic               ball_pix,
   input  logic               pad1_pix,
   input  logic               pad2_pix,
   input  logic               serve,
   output logic               collision,
   output logic [2:0]         hit_code,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               game_over
);

   localparam int unsigned CNT_W   = 10;
   localparam int unsigned FLAG_W  = 6;
   localparam int unsigned CODE_W  = 3;

   // Flag bit positions, listed in priority order (lowest index wins).
   localparam int unsigned F_TOP = 0;
   localparam int unsigned F_BOT = 1;
   localparam int unsigned F_P1  = 2;
   localparam int unsigned F_P2  = 3;
   localparam int unsigned F_GL  = 4;
   localparam int unsigned F_GR  = 5;

   localparam logic [CODE_W-1:0] CODE_NONE = CODE_W'(0);
   localparam logic [CODE_W-1:0] CODE_GL   = CODE_W'(5);
   localparam logic [CODE_W-1:0] CODE_GR   = CODE_W'(6);

   typedef enum logic {
      SCAN = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                vsync_q;
   logic [FLAG_W-1:0]   flags;
   logic [FLAG_W-1:0]   pix_hits_c;
   logic [CODE_W-1:0]   code_c;
   logic                active_c;
   logic                publish_c;
   logic                vs_rise_c;

   assign active_c  = (hcount < CNT_W'(H_ACTIVE)) && (vcount < CNT_W'(V_ACTIVE));
   assign publish_c = (hcount == CNT_W'(0)) && (vcount == CNT_W'(V_ACTIVE));
   assign vs_rise_c = !vsync_q && vsync;

   // Per-pixel hit classification for the current raster position.
   always_comb begin
      pix_hits_c        = '0;
      pix_hits_c[F_TOP] = ball_pix && (vcount <  CNT_W'(WALL_W));
      pix_hits_c[F_BOT] = ball_pix && (vcount >= CNT_W'(V_ACTIVE - WALL_W));
      pix_hits_c[F_P1]  = ball_pix && pad1_pix;
      pix_hits_c[F_P2]  = ball_pix && pad2_pix;
      pix_hits_c[F_GL]  = ball_pix && (hcount <  CNT_W'(GOAL_W));
      pix_hits_c[F_GR]  = ball_pix && (hcount >= CNT_W'(H_ACTIVE - GOAL_W));
   end

   // Priority encoder over the sticky flags: top>bot>p1>p2>gl>gr.
   always_comb begin
      code_c = CODE_NONE;
      if (flags[F_TOP])      code_c = CODE_W'(1);
      else if (flags[F_BOT]) code_c = CODE_W'(2);
      else if (flags[F_P1])  code_c = CODE_W'(3);
      else if (flags[F_P2])  code_c = CODE_W'(4);
      else if (flags[F_GL])  code_c = CODE_GL;
      else if (flags[F_GR])  code_c = CODE_GR;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= SCAN;
      else       state <= state_nxt;
   end

   // Next state: publish enters (or re-enters) HOLD; vsync rise returns to SCAN.
   always_comb begin
      state_nxt = state;
      case (state)
         SCAN: if (publish_c) state_nxt = HOLD;
         HOLD: begin
            if (publish_c)      state_nxt = HOLD;
            else if (vs_rise_c) state_nxt = SCAN;
         end
         default: state_nxt = SCAN;
      endcase
   end

   // vsync delay for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) vsync_q <= 1'b1;
      else       vsync_q <= vsync;
   end

   // Sticky flags: accumulate during active SCAN, cleared on publish.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           flags <= '0;
      else if (publish_c)                  flags <= '0;
      else if (state == SCAN && active_c)  flags <= flags | pix_hits_c;
   end

   // Published collision level and hit code, held until the vsync rise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         collision <= 1'b0;
         hit_code  <= CODE_NONE;
      end else if (publish_c) begin
         collision <= |flags;
         hit_code  <= code_c;
      end else if (state == HOLD && vs_rise_c) begin
         collision <= 1'b0;
         hit_code  <= CODE_NONE;
      end
   end

`ifdef PONG_SCORE_EN
   logic goal_lock;
   logic score_c;

   assign score_c = publish_c && ((code_c == CODE_GL) || (code_c == CODE_GR))
                    && !goal_lock && !game_over;

   // Goal scoring with per-serve lock; scores freeze once game_over is set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score1    <= '0;
         score2    <= '0;
         game_over <= 1'b0;
         goal_lock <= 1'b0;
      end else if (score_c) begin
         goal_lock <= 1'b1;
         if (code_c == CODE_GL) begin
            score2 <= score2 + SCORE_W'(1);
            if (score2 + SCORE_W'(1) == SCORE_W'(MAX_SCORE)) game_over <= 1'b1;
         end else begin
            score1 <= score1 + SCORE_W'(1);
            if (score1 + SCORE_W'(1) == SCORE_W'(MAX_SCORE)) game_over <= 1'b1;
         end
      end else if (serve) begin
         goal_lock <= 1'b0;
      end
   end
`else
   logic unused_serve;

   assign unused_serve = serve;
   assign score1       = '0;
   assign score2       = '0;
   assign game_over    = 1'b0;
`endif

endmodule
